seq_101_stream_gen: RTL
=======================

# seq_101_stream_gen

Serial stimulus source for the "101" Mealy sequence detectors: it loads a parallel frame of up to WIDTH bits and shifts it out MSB-first, one bit per clock, on a single-bit data line that feeds a detector's `d` input. It also runs an internal golden model of the non-overlapping Mealy 101 detector on the transmitted bits. That model produces an expected-`z` strobe aligned with each transmitted bit and a per-frame detection count. The block sits on the driving side of the detector in self-checking test harnesses and on-board pattern injectors.

## Interface
- WIDTH, default 16: maximum frame length in bits.
- LEN_W, default 5: width of `len` and `hit_cnt`; must satisfy 2^LEN_W > WIDTH.

- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high.
- start  in  1  frame request; accepted only when `ready`=1.
- frame  in  WIDTH  frame bits; only the low `len` bits are used, transmitted from bit len-1 down to bit 0.
- len  in  LEN_W  number of bits to send; 0 gives an empty frame; values above WIDTH are clamped to WIDTH.
- ready  out  1  idle, and able to accept `start`.
- d_out  out  1  serial data bit; 0 whenever `valid`=0.
- valid  out  1  `d_out` carries a frame bit this cycle.
- z_exp  out  1  expected Mealy detector output for the current `d_out` bit.
- done  out  1  single-cycle pulse after the last bit of a frame.
- hit_cnt  out  LEN_W  number of `z_exp` pulses in the current or most recent frame.

## Operation
- The FSM has two states: IDLE and SEND.
- **IDLE.** `ready`=1. On `start`=1:
  - capture `frame` and the clamped `len`;
  - clear `hit_cnt`;
  - reset the golden model to S0.
  - If clamped len=0: stay in IDLE and pulse `done` next cycle. `hit_cnt` stays 0 and `valid` is never asserted.
  - Otherwise: go to SEND.
- **SEND.** `ready`=0. Each cycle presents one bit on `d_out` with `valid`=1, MSB of the used field first. This lasts exactly len cycles.
  - After the last bit: return to IDLE; `done`=1 for one cycle, coincident with `ready`=1.
- Inputs `frame` and `len` are ignored outside the accept cycle. `start` is ignored while `ready`=0.
- A `start` in the `done` cycle is accepted. The new frame's first bit appears on the following cycle, so frames are separated by exactly one idle cycle.
- **Golden model states:**
  - S0: nothing matched.
  - S1: seen "1".
  - S2: seen "10".
- **Golden model transitions**, evaluated on each valid bit b:
  - S0: b=1 → S1; b=0 → S0.
  - S1: b=0 → S2; b=1 → S1.
  - S2: b=1 → S0 with a hit; b=0 → S0.
- The model is non-overlapping: after a hit it returns to S0, not S1.
- `z_exp` = `valid` AND (model state is S2) AND `d_out`. This is a Mealy output, combinational from registered state and `d_out` only; it has no combinational path from any input port.
- `hit_cnt` increments in the cycle after each `z_exp`=1. It is final in the `done` cycle and holds until the next accepted `start`.

## Timing
- **Reset values**, valid at the first rising edge with `rst`=1:
  - FSM in IDLE, so `ready`=1;
  - `d_out`=0, `valid`=0, `z_exp`=0, `done`=0, `hit_cnt`=0;
  - golden model in S0.
- `rst` overrides `start` in the same cycle.
- Reset mid-frame aborts the frame at that edge. No `done` is issued and no further bits are sent.
- **Latency:** start is accepted at edge N; the first bit is valid in cycle N+1; the last bit is valid in cycle N+len; `done` is in cycle N+len+1.
- `d_out`, `valid`, `ready` and `done` are registered outputs.
- A downstream detector clocked on the same `clk` samples `d_out` at edge N+k. Its `z` in cycle N+k must equal `z_exp` in that cycle.

## Test plan
- **Reset.** Hold `rst`=1 for 2 cycles with `start`=1, `len`=5 → `ready`=1, `valid`=0, `d_out`=0, `hit_cnt`=0 throughout; no `done` pulse.
- **Single hit.** `len`=5, `frame`=16'h0015 (10101) →
  - `d_out` = 1,0,1,0,1 over 5 cycles;
  - `z_exp` high on bit 3 only, not on bit 5 (non-overlap);
  - `done` in cycle 6; `hit_cnt`=1.
- **Multi-hit.** `len`=12, `frame`=16'h05AD (bits 0101_1010_1101) →
  - `z_exp` on bits 4, 7 and 12;
  - `hit_cnt`=3;
  - `valid` high exactly 12 cycles.
- **Handshake.**
  - Pulse `start` again during SEND → it is ignored and the frame is unchanged.
  - Assert `start` in the `done` cycle with `len`=3, `frame`=3'b101 → first bit appears next cycle; `z_exp` on bit 3; `hit_cnt`=1.
- **Length bounds.**
  - `len`=0 → `done` one cycle after acceptance; `valid` never asserted; `hit_cnt`=0.
  - `len`=20 with `frame`=16'hAAAA → clamped to 16 bits; `valid` high 16 cycles; `hit_cnt`=4.
- **Mid-frame reset.** Assert `rst` on cycle 3 of a 12-bit frame → the next cycle shows `valid`=0, `ready`=1, `hit_cnt`=0, with no `done` pulse. A new `start` afterwards transmits normally.

Source files
------------

// File: rtl/seq_101_stream_gen.sv
// seq_101_stream_gen: shifts a parallel frame out MSB-first on a serial line
// and runs a golden non-overlapping Mealy "101" detector on the sent bits,
// giving an expected-z strobe per bit and a per-frame hit count.
module seq_101_stream_gen #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] frame,
  input  logic [LEN_W-1:0] len,
  output logic             ready,
  output logic             d_out,
  output logic             valid,
  output logic             z_exp,
  output logic             done,
  output logic [LEN_W-1:0] hit_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } gold_t;

  localparam logic [LEN_W-1:0] WIDTH_L = LEN_W'(WIDTH);

  state_t           state, state_n;
  gold_t            gstate, gstate_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [LEN_W-1:0] rem, rem_n;
  logic [LEN_W-1:0] hit_n;
  logic             d_n, valid_n, done_n, ready_n;

  logic [LEN_W-1:0] len_clamped;
  logic [LEN_W-1:0] shift_amt;
  logic [WIDTH-1:0] aligned;

  // Clamp the requested length and left-justify the used field so the
  // first bit to send sits at the MSB; unused upper bits fall off the top.
  always_comb begin
    len_clamped = (len > WIDTH_L) ? WIDTH_L : len;
    shift_amt   = WIDTH_L - len_clamped;
    aligned     = frame << shift_amt;
  end

  // Mealy strobe: a 1 arriving while the model has already seen "10".
  assign z_exp = valid & (gstate == S2) & d_out;

  // Next-state logic for the sender FSM and the golden detector model.
  always_comb begin
    state_n  = state;
    gstate_n = gstate;
    shreg_n  = shreg;
    rem_n    = rem;
    hit_n    = hit_cnt;
    d_n      = 1'b0;
    valid_n  = 1'b0;
    done_n   = 1'b0;

    if (valid) begin
      case (gstate)
        S0: gstate_n = d_out ? S1 : S0;
        S1: gstate_n = d_out ? S1 : S2;
        S2: gstate_n = S0;
        default: gstate_n = S0;
      endcase
      if (z_exp) begin
        hit_n = hit_cnt + LEN_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (start) begin
          hit_n    = '0;
          gstate_n = S0;
          if (len_clamped == '0) begin
            done_n = 1'b1;
          end else begin
            state_n = SEND;
            valid_n = 1'b1;
            d_n     = aligned[WIDTH-1];
            shreg_n = aligned << 1;
            rem_n   = len_clamped - LEN_W'(1);
          end
        end
      end
      SEND: begin
        if (rem == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          valid_n = 1'b1;
          d_n     = shreg[WIDTH-1];
          shreg_n = shreg << 1;
          rem_n   = rem - LEN_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    ready_n = (state_n == IDLE);
  end

  // State and registered outputs; reset aborts any frame without a done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      gstate  <= S0;
      shreg   <= '0;
      rem     <= '0;
      hit_cnt <= '0;
      d_out   <= 1'b0;
      valid   <= 1'b0;
      done    <= 1'b0;
      ready   <= 1'b1;
    end else begin
      state   <= state_n;
      gstate  <= gstate_n;
      shreg   <= shreg_n;
      rem     <= rem_n;
      hit_cnt <= hit_n;
      d_out   <= d_n;
      valid   <= valid_n;
      done    <= done_n;
      ready   <= ready_n;
    end
  end

endmodule
